// File: rtl/sstv_cal_track.sv
// sstv_cal_track: walks the SSTV calibration header (leader/break/leader/start bit) with glitch filtering.
// Define SSTV_CAL_OFFSET_EN to measure the mean leader-2 offset from 1900 Hz.
module sstv_cal_track #(
  parameter int FREQ_W       = 12,
  parameter int TOL          = 50,
  parameter int LEADER_MIN   = 27000,
  parameter int BREAK_MIN    = 700,
  parameter int BREAK_MAX    = 1300,
  parameter int START_TICKS  = 3000,
  parameter int GLITCH_TICKS = 20,
  parameter int AVG_LOG2     = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [FREQ_W-1:0]        freq,
  input  logic                     rearm,
  output logic                     cal_active,
  output logic                     cal_ok,
  output logic                     cal_fail,
  output logic signed [FREQ_W:0]   offset,
  output logic                     offset_valid
);
  localparam int SW = FREQ_W + 1;
  localparam int D1 = LEADER_MIN > START_TICKS ? LEADER_MIN : START_TICKS;
  localparam int D2 = D1 > BREAK_MAX + 1 ? D1 : BREAK_MAX + 1;
  localparam int D3 = D2 > (1 << AVG_LOG2) ? D2 : (1 << AVG_LOG2);
  localparam int DW = $clog2(D3 + 1);
  localparam int GW = $clog2(GLITCH_TICKS + 1);
  localparam logic [DW-1:0] L_MIN = DW'(LEADER_MIN);
  localparam logic [DW-1:0] B_MIN = DW'(BREAK_MIN);
  localparam logic [DW-1:0] B_MAX = DW'(BREAK_MAX);
  localparam logic [DW-1:0] S_TCK = DW'(START_TICKS);
  localparam logic [GW-1:0] G_TCK = GW'(GLITCH_TICKS);
  localparam logic signed [SW-1:0] C_HI  = SW'(1900);
  localparam logic signed [SW-1:0] C_LO  = SW'(1200);
  localparam logic signed [SW-1:0] TOL_S = SW'(TOL);

  typedef enum logic [2:0] {IDLE, LEADER1, BREAK, LEADER2, START, DONE} state_t;

  state_t state_q, state_d;
  logic [DW-1:0] dur_q, dur_d, dur_inc;
  logic [GW-1:0] glitch_q, glitch_d, glitch_inc;
  logic signed [SW-1:0] d_hi, d_lo;
  logic in_hi, in_lo, abort, glitch_abort;
  logic cal_active_q, cal_ok_q, cal_fail_q;

  assign d_hi = $signed({1'b0, freq}) - C_HI;
  assign d_lo = $signed({1'b0, freq}) - C_LO;
  assign in_hi = d_hi >= -TOL_S && d_hi <= TOL_S;
  assign in_lo = d_lo >= -TOL_S && d_lo <= TOL_S;
  assign dur_inc = &dur_q ? dur_q : dur_q + DW'(1);
  assign glitch_inc = glitch_q + GW'(1);
  assign glitch_abort = glitch_inc == G_TCK;

  always_comb begin
    state_d  = state_q;
    dur_d    = dur_q;
    glitch_d = '0;
    abort    = 1'b0;
    case (state_q)
      IDLE: if (in_hi) begin
        state_d = LEADER1;
        dur_d   = DW'(1);
      end
      LEADER1, LEADER2: if (in_hi) dur_d = dur_inc;
        else if (in_lo && dur_q >= L_MIN) begin
          state_d = state_q == LEADER1 ? BREAK : START;
          dur_d   = DW'(1);
        end else begin
          glitch_d = glitch_inc;
          abort    = glitch_abort;
        end
      BREAK: if (in_lo) begin
          dur_d = dur_inc;
          abort = dur_inc > B_MAX;
        end else if (in_hi) begin
          state_d = LEADER2;
          dur_d   = DW'(1);
          abort   = dur_q < B_MIN;
        end else begin
          glitch_d = glitch_inc;
          abort    = glitch_abort;
        end
      START: if (in_lo) begin
          dur_d   = dur_inc;
          state_d = dur_inc == S_TCK ? DONE : START;
        end else if (in_hi) abort = 1'b1;
        else begin
          glitch_d = glitch_inc;
          abort    = glitch_abort;
        end
      DONE: state_d = rearm ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    if (state_d == IDLE || state_d == DONE) begin
      dur_d    = '0;
      glitch_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dur_q        <= '0;
      glitch_q     <= '0;
      cal_active_q <= 1'b0;
      cal_ok_q     <= 1'b0;
      cal_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dur_q        <= dur_d;
      glitch_q     <= glitch_d;
      cal_active_q <= state_d inside {LEADER1, BREAK, LEADER2, START};
      cal_ok_q     <= state_d == DONE;
      cal_fail_q   <= abort;
    end
  end

  assign cal_active = cal_active_q;
  assign cal_ok     = cal_ok_q;
  assign cal_fail   = cal_fail_q;

`ifdef SSTV_CAL_OFFSET_EN
  localparam int AW = SW + AVG_LOG2;
  localparam logic [DW-1:0] N_AVG = DW'(1 << AVG_LOG2);
  logic signed [AW-1:0] acc_q, acc_d, d_ext;
  logic signed [SW-1:0] offset_q;
  logic offset_valid_q, to_done;

  assign d_ext   = {{AVG_LOG2{d_hi[SW-1]}}, d_hi};
  assign to_done = state_q == START && state_d == DONE;

  // first leader-2 sample seeds the sum; the next 2^AVG_LOG2-1 in-band samples add to it
  always_comb begin
    acc_d = acc_q;
    if (state_q == BREAK && state_d == LEADER2) acc_d = d_ext;
    else if (state_q == LEADER2 && state_d == LEADER2 && in_hi && dur_q < N_AVG) acc_d = acc_q + d_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q          <= '0;
      offset_q       <= '0;
      offset_valid_q <= 1'b0;
    end else begin
      acc_q          <= acc_d;
      offset_q       <= to_done ? SW'(acc_q >>> AVG_LOG2) : offset_q;
      offset_valid_q <= to_done;
    end
  end

  assign offset       = offset_q;
  assign offset_valid = offset_valid_q;
`else
  assign offset       = '0;
  assign offset_valid = 1'b0;
`endif
endmodule

// File: tb/tb_sstv_cal_track.sv
// tb_sstv_cal_track: vector table, corner sequences and random headers checked against a tick-level behavioural model.
module tb_sstv_cal_track;
  localparam int FW = 12, TOL = 50, LMIN = 300, BMIN = 70, BMAX = 130, ST = 30, G = 20, A = 6;
  localparam int N = 1 << A;

  logic clk = 1'b0, reset = 1'b1, rearm = 1'b0;
  logic [FW-1:0] freq = '0;
  logic cal_active, cal_ok, cal_fail, offset_valid;
  logic signed [FW:0] offset;

  always #5 clk = ~clk;

  sstv_cal_track #(.FREQ_W(FW), .TOL(TOL), .LEADER_MIN(LMIN), .BREAK_MIN(BMIN), .BREAK_MAX(BMAX),
    .START_TICKS(ST), .GLITCH_TICKS(G), .AVG_LOG2(A)) dut (
    .clk(clk), .reset(reset), .freq(freq), .rearm(rearm), .cal_active(cal_active), .cal_ok(cal_ok),
    .cal_fail(cal_fail), .offset(offset), .offset_valid(offset_valid));

  int checks = 0, errors = 0, fails_seen = 0, ov_seen = 0;
  int m_ph = 0, m_dur = 0, m_gl = 0, m_acc = 0, m_off = 0;
  bit m_fail = 0, m_ov = 0;

  typedef struct {int f1; int n1; int f2; int n2; int f3; int n3; int f4; int n4; bit ok; int nf; int off;} vec_t;
  vec_t v[14];

  function automatic void check(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endfunction

  function automatic int band(int f);
    if (f >= 1900 - TOL && f <= 1900 + TOL) return 1;
    if (f >= 1200 - TOL && f <= 1200 + TOL) return 2;
    return 0;
  endfunction

  function automatic void m_abort();
    m_ph = 0; m_dur = 0; m_gl = 0; m_fail = 1;
  endfunction

  function automatic void m_glitch();
    m_gl++;
    if (m_gl >= G) m_abort();
  endfunction

  // phases: 0 idle, 1 leader1, 2 break, 3 leader2, 4 start bit, 5 done
  function automatic void m_step(int f, bit rr, bit rs);
    int b = band(f);
    m_fail = 0; m_ov = 0;
    if (rs) begin
      m_ph = 0; m_dur = 0; m_gl = 0; m_acc = 0; m_off = 0;
      return;
    end
    case (m_ph)
      0: if (b == 1) begin m_ph = 1; m_dur = 1; end
      1, 3: if (b == 1) begin
          m_dur++; m_gl = 0;
          if (m_ph == 3 && m_dur <= N) m_acc += f - 1900;
        end else if (b == 2 && m_dur >= LMIN) begin m_ph++; m_dur = 1; m_gl = 0; end
        else m_glitch();
      2: if (b == 2) begin
          m_dur++; m_gl = 0;
          if (m_dur > BMAX) m_abort();
        end else if (b == 1) begin
          if (m_dur >= BMIN) begin m_ph = 3; m_dur = 1; m_gl = 0; m_acc = f - 1900; end
          else m_abort();
        end else m_glitch();
      4: if (b == 2) begin
          m_dur++; m_gl = 0;
          if (m_dur == ST) begin
            m_ph = 5; m_ov = 1;
            m_off = m_acc >= 0 ? m_acc / N : -((-m_acc + N - 1) / N);
          end
        end else if (b == 1) m_abort();
        else m_glitch();
      default: if (rr) m_ph = 0;
    endcase
  endfunction

  task automatic tick(input int f, input bit rr = 0, input bit rs = 0);
    logic [16:0] got, want;
    logic signed [FW:0] eoff;
    bit eov;
    freq = FW'(f); rearm = rr; reset = rs;
    @(posedge clk);
    m_step(f, rr, rs);
    #1;
`ifdef SSTV_CAL_OFFSET_EN
    eoff = m_off[FW:0]; eov = m_ov;
`else
    eoff = '0; eov = 1'b0;
`endif
    got  = {cal_active, cal_ok, cal_fail, offset_valid, offset};
    want = {m_ph >= 1 && m_ph <= 4, m_ph == 5, m_fail, eov, eoff};
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL tick f=%0d: got act/ok/fail/ov/off=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d (t=%0t)",
        f, got[16], got[15], got[14], got[13], offset, want[16], want[15], want[14], want[13], eoff, $time);
    end
    if (cal_fail) fails_seen++;
    if (offset_valid) ov_seen++;
  endtask

  task automatic seg(input int f, input int n);
    repeat (n) tick(f);
  endtask

  task automatic nominal();
    seg(1900, 330); seg(1200, 100); seg(1900, 330); seg(1200, 30);
  endtask

  initial begin
    int fb, ob, ce, l1, bl, l2, sl, eo;
    v[0]  = '{1900, 330, 1200, 100, 1900, 330, 1200, 30, 1'b1, 0, 0};
    v[1]  = '{1930, 330, 1200, 100, 1930, 330, 1200, 30, 1'b1, 0, 30};
    v[2]  = '{1873, 330, 1200, 100, 1873, 330, 1200, 30, 1'b1, 0, -27};
    v[3]  = '{1950, 330, 1250, 100, 1950, 330, 1250, 30, 1'b1, 0, 50};
    v[4]  = '{1900, 330, 1200, 130, 1900, 330, 1200, 30, 1'b1, 0, 0};
    v[5]  = '{1900, 330, 1200, 131, 1900, 330, 1200, 30, 1'b0, 1, 0};
    v[6]  = '{1900, 330, 1200, 70, 1900, 330, 1200, 30, 1'b1, 0, 0};
    v[7]  = '{1900, 330, 1200, 69, 1900, 330, 1200, 30, 1'b0, 1, 0};
    v[8]  = '{1900, 200, 1200, 40, 0, 0, 0, 0, 1'b0, 1, 0};
    v[9]  = '{1900, 330, 1200, 100, 1900, 330, 1200, 29, 1'b0, 0, 0};
    v[10] = '{1900, 330, 1200, 100, 1900, 299, 1200, 30, 1'b0, 1, 0};
    v[11] = '{1900, 300, 1200, 100, 1900, 300, 1200, 30, 1'b1, 0, 0};
    v[12] = '{1951, 330, 1200, 100, 1951, 330, 1200, 30, 1'b0, 0, 0};
    v[13] = '{1850, 330, 1150, 100, 1850, 330, 1180, 30, 1'b1, 0, -50};
    tick(0, 0, 1); tick(0, 0, 1);
    check("reset_active", cal_active, 0);
    check("reset_offset", offset, 0);
    for (int i = 0; i < 14; i++) begin
      fb = fails_seen; ob = ov_seen;
      seg(v[i].f1, v[i].n1); seg(v[i].f2, v[i].n2); seg(v[i].f3, v[i].n3); seg(v[i].f4, v[i].n4);
`ifdef SSTV_CAL_OFFSET_EN
      eo = v[i].off;
      check($sformatf("vec%0d_ov", i), ov_seen - ob, v[i].ok ? 1 : 0);
`else
      eo = 0;
      check($sformatf("vec%0d_ov", i), ov_seen - ob, 0);
`endif
      check($sformatf("vec%0d_ok", i), cal_ok, v[i].ok);
      check($sformatf("vec%0d_fails", i), fails_seen - fb, v[i].nf);
      check($sformatf("vec%0d_offset", i), offset, eo);
      tick(0, 0, 1);
    end
    fb = fails_seen;
    seg(1900, 100); seg(0, 15); seg(1900, 100); seg(0, 15); seg(1900, 120);
    seg(1200, 100); seg(1900, 330); seg(1200, 30);
    check("glitch15_ok", cal_ok, 1);
    check("glitch15_fails", fails_seen - fb, 0);
    tick(0, 0, 1);
    seg(1900, 100); seg(0, 19);
    check("glitch19_active", cal_active, 1);
    tick(0);
    check("glitch20_fail", cal_fail, 1);
    check("glitch20_active", cal_active, 0);
    tick(0);
    check("fail_one_cycle", cal_fail, 0);
    seg(1900, 330); seg(1200, 130);
    check("break130_nofail", cal_fail, 0);
    tick(1200);
    check("break131_fail", cal_fail, 1);
    check("break131_active", cal_active, 0);
    tick(0, 0, 1);
    fb = fails_seen;
    for (int f = 0; f < 4096; f++) tick(f);
    check("sweep_ok", cal_ok, 0);
    check("sweep_fails", fails_seen - fb, 1);
    seg(0, 5); seg(1900, 330); seg(1200, 100); seg(1900, 150);
    check("l2_active", cal_active, 1);
    fb = fails_seen;
    tick(1900, 0, 1);
    check("midreset_active", cal_active, 0);
    check("midreset_fail", fails_seen - fb, 0);
    nominal(); tick(0, 1, 0);
    check("rearm_ok", cal_ok, 0);
    check("rearm_active", cal_active, 0);
    nominal(); tick(0, 1, 1);
    check("rearm_reset_ok", cal_ok, 0);
    check("rearm_reset_offset", offset, 0);
    for (int r = 0; r < 30; r++) begin
      l1 = $urandom_range(280, 340); bl = $urandom_range(60, 140);
      l2 = $urandom_range(280, 340); sl = $urandom_range(20, 40);
      for (int s = 0; s < 4; s++) begin
        ce = (s % 2 == 0) ? 1900 : 1200;
        for (int k = 0; k < (s == 0 ? l1 : s == 1 ? bl : s == 2 ? l2 : sl); k++)
          if ($urandom_range(0, 299) == 0) seg(0, $urandom_range(10, 22));
          else if ($urandom_range(0, 199) == 0) tick($urandom_range(0, 4095), $urandom_range(0, 1));
          else tick(ce + $urandom_range(0, 120) - 60, $urandom_range(0, 99) == 0);
      end
      seg(0, $urandom_range(1, 5));
      tick(0, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
